attex_bus_ctrl: RTL and testbench

ATTEX_BUS_CTRL -- requirements
Module: attex_bus_ctrl

---
 rtl/attex_pkg.sv | 14 +
 rtl/attex_decode.sv | 17 +
 rtl/attex_bus_ctrl.sv | 85 ++++++++
 tb/tb_attex_bus_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/attex_pkg.sv
// attex_pkg: shared region/state encodings and address map boundaries for the attex bus controller.
package attex_pkg;
  typedef enum logic [2:0] {RGN_NONE, RGN_MCD212, RGN_CDIC, RGN_SLAVE, RGN_NVRAM, RGN_BERR} region_t;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE, ST_BERR} state_t;
  localparam logic [7:0] CDIC_PAGE = 8'h30;
  localparam logic [7:0] SLAVE_PAGE = 8'h31;
  localparam logic [7:0] NVRAM_PAGE = 8'h32;
  localparam logic [23:0] MCD_LO_END = 24'h27FFFF;
  localparam logic [23:0] MCD_HI_BASE = 24'h400000;
  localparam logic [23:0] MCD_HI_END = 24'h5FFFFF;
  localparam logic [23:0] BERR_LO_BASE = 24'h600000;
  localparam logic [23:0] BERR_LO_END = 24'hCFFFFF;
  localparam logic [23:0] BERR_HI_BASE = 24'hF00000;
endpackage

// File: rtl/attex_decode.sv
// attex_decode: combinational word-address to region decoder, first match wins.
module attex_decode
  import attex_pkg::*;
(
  input  logic [22:0] addr,
  output region_t     region
);
  logic [23:0] a;
  assign a = {addr, 1'b0};
  always_comb
    region = a[23:16] == CDIC_PAGE  ? RGN_CDIC :
             a[23:16] == SLAVE_PAGE ? RGN_SLAVE :
             a[23:16] == NVRAM_PAGE ? RGN_NVRAM :
             (a >= BERR_LO_BASE && a <= BERR_LO_END) || a >= BERR_HI_BASE ? RGN_BERR :
             a <= MCD_LO_END || (a >= MCD_HI_BASE && a <= MCD_HI_END) ? RGN_MCD212 :
             RGN_NONE;
endmodule

// File: rtl/attex_bus_ctrl.sv
// attex_bus_ctrl: CPU bus cycle FSM with chip selects, per-region acknowledge, timeout and slave IRQ timer.
module attex_bus_ctrl
  import attex_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int SLAVE_IRQ_DELAY = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        as,
  input  logic        uds,
  input  logic        lds,
  input  logic        write_strobe,
  input  logic [22:0] addr,
  input  logic        mcd212_ack,
  input  logic [15:0] mcd212_dout,
  input  logic [15:0] cdic_dout,
  input  logic [7:0]  slave_dout,
  input  logic        slave_dtack_n,
  input  logic [7:0]  nvram_dout,
  output logic        cs_mcd212,
  output logic        cs_cdic,
  output logic        cs_slave,
  output logic        cs_nvram,
  output logic        nvram_we,
  output logic [15:0] cpu_din,
  output logic        bus_ack,
  output logic        bus_err,
  output logic        slave_irq
);
  state_t      state, state_nx;
  region_t     region, dec;
  logic [15:0] tmo_cnt, irq_cnt, rd;
  logic        dtack_q, strobe, acc, ack, tmo;
  attex_decode u_decode (.addr(addr), .region(dec));
  assign strobe = as && (uds || lds);
  assign acc    = state == ST_ACCESS;
  assign tmo    = tmo_cnt == 16'(TIMEOUT_CYCLES - 1);
  // Slave acknowledges on the rising edge of its (active-low) DTACK line.
  always_comb
    ack = region == RGN_MCD212 ? mcd212_ack :
          (region == RGN_CDIC || region == RGN_NVRAM) ? tmo_cnt == 16'd1 :
          region == RGN_SLAVE ? slave_dtack_n && !dtack_q :
          1'b0;
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:         if (strobe) state_nx = dec == RGN_BERR ? ST_BERR : ST_ACCESS;
      ST_ACCESS:       state_nx = !as ? ST_IDLE : ack ? ST_DONE : tmo ? ST_BERR : ST_ACCESS;
      ST_DONE, ST_BERR: if (!as) state_nx = ST_IDLE;
      default:         state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= ST_IDLE;
      region  <= RGN_NONE;
      tmo_cnt <= '0;
      irq_cnt <= '0;
      dtack_q <= 1'b1;
    end else begin
      state   <= state_nx;
      dtack_q <= slave_dtack_n;
      if (state == ST_IDLE && strobe) region <= dec;
      if (state != ST_ACCESS && state_nx == ST_ACCESS) tmo_cnt <= '0;
      else if (acc) tmo_cnt <= tmo_cnt + 16'd1;
      if (state == ST_IDLE && state_nx == ST_ACCESS && dec == RGN_SLAVE) irq_cnt <= 16'(SLAVE_IRQ_DELAY);
      else if (irq_cnt != '0) irq_cnt <= irq_cnt - 16'd1;
    end
  always_comb
    rd = region == RGN_MCD212 ? mcd212_dout :
         region == RGN_CDIC   ? cdic_dout :
         region == RGN_NVRAM  ? {2{nvram_dout}} :
         region == RGN_SLAVE  ? (slave_dout == 8'h01 ? 16'h0202 : {2{slave_dout}}) :
         16'h0000;
  assign cpu_din   = (acc || state == ST_DONE) ? rd : 16'h0000;
  assign cs_mcd212 = acc && region == RGN_MCD212;
  assign cs_cdic   = acc && region == RGN_CDIC;
  assign cs_slave  = acc && region == RGN_SLAVE;
  assign cs_nvram  = acc && region == RGN_NVRAM;
  assign nvram_we  = cs_nvram && tmo_cnt == 16'd0 && uds && write_strobe;
  assign bus_ack   = acc && as && ack;
  assign bus_err   = state == ST_BERR && as;
  assign slave_irq = irq_cnt == 16'd1;
endmodule

// File: tb/tb_attex_bus_ctrl.sv
// tb_attex_bus_ctrl: directed and random bus cycles checked against a transaction-level reference model.
module tb_attex_bus_ctrl;
  localparam int T = 8;
  localparam int IRQ_D = 20;
  logic        clk, reset, as, uds, lds, write_strobe, mcd212_ack, slave_dtack_n;
  logic [22:0] addr;
  logic [15:0] mcd212_dout, cdic_dout, cpu_din;
  logic [7:0]  slave_dout, nvram_dout;
  logic        cs_mcd212, cs_cdic, cs_slave, cs_nvram, nvram_we, bus_ack, bus_err, slave_irq;
  int          n_checks, n_errors, irq_left;

  attex_bus_ctrl #(.TIMEOUT_CYCLES(T), .SLAVE_IRQ_DELAY(IRQ_D)) dut (
    .clk(clk), .reset(reset), .as(as), .uds(uds), .lds(lds), .write_strobe(write_strobe),
    .addr(addr), .mcd212_ack(mcd212_ack), .mcd212_dout(mcd212_dout), .cdic_dout(cdic_dout),
    .slave_dout(slave_dout), .slave_dtack_n(slave_dtack_n), .nvram_dout(nvram_dout),
    .cs_mcd212(cs_mcd212), .cs_cdic(cs_cdic), .cs_slave(cs_slave), .cs_nvram(cs_nvram),
    .nvram_we(nvram_we), .cpu_din(cpu_din), .bus_ack(bus_ack), .bus_err(bus_err),
    .slave_irq(slave_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // region codes: 0 none, 1 mcd212, 2 cdic, 3 slave, 4 nvram, 5 bus error
  function automatic int region_of(int b);
    if (b >= 'h300000 && b < 'h310000) return 2;
    if (b >= 'h310000 && b < 'h320000) return 3;
    if (b >= 'h320000 && b < 'h330000) return 4;
    if ((b >= 'h600000 && b < 'hD00000) || b >= 'hF00000) return 5;
    if (b < 'h280000 || (b >= 'h400000 && b < 'h600000)) return 1;
    return 0;
  endfunction

  function automatic int cs_mask(int r);
    return r == 1 ? 8 : r == 2 ? 4 : r == 3 ? 2 : r == 4 ? 1 : 0;
  endfunction

  function automatic logic [15:0] data_of(int r);
    case (r)
      1: return mcd212_dout;
      2: return cdic_dout;
      3: return slave_dout == 8'h01 ? 16'h0202 : {slave_dout, slave_dout};
      4: return {nvram_dout, nvram_dout};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (irq_left > 0) irq_left--;
  endtask

  task automatic check_outs(string tag, int m, bit ack, bit err, bit we, bit chk_din, logic [15:0] din);
    check({tag, "_cs"}, 32'({cs_mcd212, cs_cdic, cs_slave, cs_nvram}), 32'(m));
    check({tag, "_ack"}, 32'(bus_ack), 32'(ack));
    check({tag, "_err"}, 32'(bus_err), 32'(err));
    check({tag, "_we"}, 32'(nvram_we), 32'(we));
    check({tag, "_irq"}, 32'(slave_irq), 32'(irq_left == 1));
    if (chk_din) check({tag, "_din"}, 32'(cpu_din), 32'(din));
  endtask

  // d: cycle of the mcd212/slave acknowledge; drop_at: ACCESS-relative cycle where as falls (<=0 picks one)
  task automatic run_txn(int b, bit wr, bit u, bit l, int d, int drop_at);
    int r, ack_at, end_acc;
    r = region_of(b);
    ack_at = (r == 1 || r == 3) ? d : (r == 2 || r == 4) ? 2 : 1000;
    end_acc = r == 5 ? 0 : (ack_at <= T ? ack_at : T);
    if (drop_at <= 0)
      drop_at = (end_acc >= 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(2, end_acc))
              : (end_acc < 1 ? 1 : end_acc) + int'($urandom_range(1, 3));
    next_cycle();
    addr = b[23:1]; as = 1'b1; uds = u; lds = l; write_strobe = wr;
    slave_dtack_n = 1'b0; mcd212_ack = 1'b0;
    @(negedge clk);
    check_outs("start", 0, 0, 0, 0, 1, 16'h0);
    for (int k = 1; k <= drop_at; k++) begin
      next_cycle();
      if (k == 1 && r == 3) irq_left = IRQ_D;
      mcd212_ack = r == 1 && k == d;
      slave_dtack_n = r == 3 && k >= d;
      as = k < drop_at;
      @(negedge clk);
      if (k <= end_acc)
        check_outs("access", cs_mask(r), as && k == ack_at, 0, k == 1 && r == 4 && u && wr, 1, data_of(r));
      else if (r != 5 && ack_at <= T)
        check_outs("done", 0, 0, 0, 0, 0, 16'h0);
      else
        check_outs("berr", 0, 0, as, 0, 0, 16'h0);
    end
    next_cycle();
    mcd212_ack = 1'b0; slave_dtack_n = 1'b0; uds = 1'b0; lds = 1'b0; write_strobe = 1'b0;
    @(negedge clk);
    check_outs("idle", 0, 0, 0, 0, 1, 16'h0);
  endtask

  function automatic int random_byte();
    int b;
    case ($urandom_range(0, 8))
      0: b = $urandom_range(0, 'h27FFFF);
      1: b = $urandom_range('h400000, 'h5FFFFF);
      2: b = 'h300000 + $urandom_range(0, 'hFFFF);
      3: b = 'h310000 + $urandom_range(0, 'hFFFF);
      4: b = 'h320000 + $urandom_range(0, 'hFFFF);
      5: b = $urandom_range('h600000, 'hCFFFFF);
      6: b = $urandom_range('hF00000, 'hFFFFFF);
      7: b = $urandom_range('h280000, 'h2FFFFF);
      default: b = $urandom & 'hFFFFFF;
    endcase
    return b & 'hFFFFFE;
  endfunction

  task automatic randomize_data();
    mcd212_dout = 16'($urandom);
    cdic_dout = 16'($urandom);
    nvram_dout = 8'($urandom);
    slave_dout = $urandom_range(0, 3) == 0 ? 8'h01 : 8'($urandom);
  endtask

  initial begin
    int bounds[10] = '{'h27FFFE, 'h280000, 'h3FFFFE, 'h400000, 'h5FFFFE,
                       'h600000, 'hCFFFFE, 'hD00000, 'hEFFFFE, 'hF00000};
    n_checks = 0; n_errors = 0; irq_left = 0;
    reset = 1'b1; as = 1'b0; uds = 1'b0; lds = 1'b0; write_strobe = 1'b0; addr = '0;
    mcd212_ack = 1'b0; slave_dtack_n = 1'b0;
    mcd212_dout = 16'hAAAA; cdic_dout = 16'h5555; slave_dout = 8'h33; nvram_dout = 8'h44;
    @(negedge clk);
    check_outs("reset", 0, 0, 0, 0, 1, 16'h0);
    next_cycle();
    reset = 1'b0;
    cdic_dout = 16'h1234;
    run_txn('h300010, 0, 1, 1, 0, 0);
    randomize_data();
    run_txn('h320004, 1, 1, 0, 0, 0);
    slave_dout = 8'h01;
    run_txn('h310000, 0, 1, 1, 5, 22);
    run_txn('h700000, 0, 1, 1, 0, 0);
    run_txn('h280000, 0, 1, 1, 0, 11);
    run_txn('h280000, 0, 1, 1, 0, 4);
    run_txn('h000100, 0, 1, 1, 8, 10);
    foreach (bounds[i]) begin
      randomize_data();
      run_txn(bounds[i], 1'($urandom_range(0, 1)), 1, 1, int'($urandom_range(1, 10)), 0);
    end
    for (int n = 0; n < 60; n++) begin
      bit u, l;
      randomize_data();
      u = 1'($urandom_range(0, 1));
      l = u ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(random_byte(), 1'($urandom_range(0, 1)), u, l, int'($urandom_range(1, 10)), 0);
    end
    mcd212_dout = 16'hBEEF;
    next_cycle();
    addr = 23'h000100; as = 1'b1; uds = 1'b1; lds = 1'b1;
    @(negedge clk);
    check_outs("rst_start", 0, 0, 0, 0, 1, 16'h0);
    for (int k = 1; k <= 2; k++) begin
      next_cycle();
      @(negedge clk);
      check_outs("rst_access", 8, 0, 0, 0, 1, 16'hBEEF);
    end
    next_cycle();
    reset = 1'b1; as = 1'b0; uds = 1'b0; lds = 1'b0; irq_left = 0;
    @(negedge clk);
    check_outs("rst_abort", 0, 0, 0, 0, 1, 16'h0);
    next_cycle();
    reset = 1'b0; mcd212_ack = 1'b1;
    @(negedge clk);
    check_outs("rst_after", 0, 0, 0, 0, 1, 16'h0);
    next_cycle();
    mcd212_ack = 1'b0;
    @(negedge clk);
    check_outs("rst_after2", 0, 0, 0, 0, 1, 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
